// File: rtl/score_sequencer.sv
// Score sequencer: walks a fixed (note, duration) ROM at a programmable beat rate.
// Optional macro SEQ_LOOP_EN makes the END marker wrap back to entry 0 instead of stopping.
module score_sequencer #(
    parameter int TICK_DIV  = 12_500_000,
    parameter int GAP_CYC   = 1_250_000,
    parameter int SCORE_LEN = 32
) (
    input  logic       sys_CLK,
    input  logic       sys_RST,
    input  logic       play,
    input  logic       restart,
    output logic [4:0] note,
    output logic       note_on,
    output logic       tick,
    output logic [4:0] pos,
    output logic       done
);

    // One spare bit so TICK_DIV-GAP_CYC still fits when GAP_CYC is 0.
    localparam int              PW        = $clog2(TICK_DIV + 1);
    localparam logic [PW-1:0]   PCNT_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]   GAP_START = PW'(TICK_DIV - GAP_CYC);
    localparam logic [4:0]      LAST_IDX  = 5'(SCORE_LEN - 1);
    localparam logic [4:0]      END_CODE  = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_DONE
    } state_t;

    function automatic logic [7:0] rom_entry(input logic [4:0] idx);
        logic [7:0] e;
        case (idx)
            5'd0:    e = {5'd3,  3'd3};
            5'd1:    e = {5'd5,  3'd2};
            5'd2:    e = {5'd0,  3'd0};
            5'd3:    e = {5'd8,  3'd1};
            5'd4:    e = {END_CODE, 3'd0};
            5'd5:    e = {5'd8,  3'd1};
            5'd6:    e = {5'd10, 3'd1};
            5'd7:    e = {5'd12, 3'd1};
            5'd8:    e = {5'd13, 3'd3};
            5'd9:    e = {5'd0,  3'd0};
            5'd10:   e = {5'd15, 3'd1};
            5'd11:   e = {5'd13, 3'd1};
            5'd12:   e = {5'd12, 3'd1};
            5'd13:   e = {5'd10, 3'd7};
            default: e = {END_CODE, 3'd0};
        endcase
        return e;
    endfunction

    state_t        state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    beats_q, beats_d;
    logic [4:0]    pos_q, pos_d;
    logic [4:0]    note_q, note_d;
    logic          note_on_q, note_on_d;
    logic          tick_q, tick_d;
    logic          done_q, done_d;

    logic [7:0]    entry0;
    logic [7:0]    nxt_entry;
    logic [4:0]    nxt_pos;
    logic          nxt_is_end;
    logic          gap_d;

    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        beats_d    = beats_q;
        pos_d      = pos_q;
        note_d     = note_q;
        tick_d     = 1'b0;
        done_d     = done_q;

        entry0     = rom_entry(5'd0);
        nxt_pos    = pos_q + 5'd1;
        nxt_entry  = rom_entry(nxt_pos);
        // The last ROM slot terminates the score even without an explicit END.
        nxt_is_end = (nxt_entry[7:3] == END_CODE) || (nxt_pos == LAST_IDX);

        if (restart) begin
            pos_d   = '0;
            pcnt_d  = '0;
            done_d  = 1'b0;
            note_d  = entry0[7:3];
            beats_d = {1'b0, entry0[2:0]} + 4'd1;
            state_d = play ? S_PLAY : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (play) begin
                        pos_d   = '0;
                        pcnt_d  = '0;
                        note_d  = entry0[7:3];
                        beats_d = {1'b0, entry0[2:0]} + 4'd1;
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (play) begin
                        if (pcnt_q == PCNT_LAST) begin
                            pcnt_d = '0;
                            tick_d = 1'b1;
                            if (beats_q == 4'd1) begin
                                if (nxt_is_end) begin
`ifdef SEQ_LOOP_EN
                                    pos_d   = '0;
                                    note_d  = entry0[7:3];
                                    beats_d = {1'b0, entry0[2:0]} + 4'd1;
`else
                                    pos_d   = nxt_pos;
                                    note_d  = '0;
                                    done_d  = 1'b1;
                                    state_d = S_DONE;
`endif
                                end else begin
                                    pos_d   = nxt_pos;
                                    note_d  = nxt_entry[7:3];
                                    beats_d = {1'b0, nxt_entry[2:0]} + 4'd1;
                                end
                            end else begin
                                beats_d = beats_q - 4'd1;
                            end
                        end else begin
                            pcnt_d = pcnt_q + PW'(1);
                        end
                    end
                end
                S_DONE: begin
                    note_d = '0;
                    done_d = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef SEQ_LOOP_EN
        done_d = 1'b0;
`endif

        // Gate is computed from the post-edge values so it lines up with the registered note.
        gap_d     = (beats_d == 4'd1) && (pcnt_d >= GAP_START);
        note_on_d = (note_d != 5'd0) && play && (state_d == S_PLAY) && !gap_d;
    end

    always_ff @(posedge sys_CLK or posedge sys_RST) begin
        if (sys_RST) begin
            state_q   <= S_IDLE;
            pcnt_q    <= '0;
            beats_q   <= 4'd1;
            pos_q     <= '0;
            note_q    <= '0;
            note_on_q <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            beats_q   <= beats_d;
            pos_q     <= pos_d;
            note_q    <= note_d;
            note_on_q <= note_on_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign note    = note_q;
    assign note_on = note_on_q;
    assign tick    = tick_q;
    assign pos     = pos_q;
    assign done    = done_q;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer at TICK_DIV=10, GAP_CYC=2; per-entry expectations go
// through a scoreboard queue and are compared when the DUT moves on to the next entry.
module tb_score_sequencer;

    logic       sys_CLK;
    logic       sys_RST;
    logic       play;
    logic       restart;
    logic [4:0] note;
    logic       note_on;
    logic       tick;
    logic [4:0] pos;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] pos;
        logic [4:0] note;
        int         len;
        int         on;
        int         ticks;
    } exp_t;

    exp_t sb[$];

    score_sequencer #(
        .TICK_DIV (10),
        .GAP_CYC  (2),
        .SCORE_LEN(32)
    ) dut (
        .sys_CLK(sys_CLK),
        .sys_RST(sys_RST),
        .play   (play),
        .restart(restart),
        .note   (note),
        .note_on(note_on),
        .tick   (tick),
        .pos    (pos),
        .done   (done)
    );

    initial sys_CLK = 1'b0;
    always #5 sys_CLK = ~sys_CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge sys_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called while sitting in the first cycle of an entry; runs until pos/note change.
    // Ticks are counted from cycle 2 up to and including the first cycle of the next entry.
    task automatic consume(input int pause_at, input int pause_len);
        exp_t e;
        int   len;
        int   on;
        int   tk;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e   = sb.pop_front();
        len = 0;
        on  = 0;
        tk  = 0;
        while (pos === e.pos && note === e.note && len < 200) begin
            len++;
            on += int'(note_on);
            if (len > 1) tk += int'(tick);
            if (pause_len > 0 && len == pause_at) play = 1'b0;
            if (pause_len > 0 && len == pause_at + pause_len) play = 1'b1;
            step();
        end
        tk += int'(tick);
        $display("entry pos=%0d note=%0d len=%0d on=%0d ticks=%0d", e.pos, e.note, len, on, tk);
        chk("entry_len",   len, e.len);
        chk("entry_on",    on,  e.on);
        chk("entry_ticks", tk,  e.ticks);
    endtask

    initial begin
        int tk_done;
        int on_done;
        int done_low;

        play    = 1'b0;
        restart = 1'b0;
        sys_RST = 1'b1;
        repeat (3) step();
        chk("rst_note",    note,    0);
        chk("rst_note_on", note_on, 0);
        chk("rst_tick",    tick,    0);
        chk("rst_pos",     pos,     0);
        chk("rst_done",    done,    0);

        sys_RST = 1'b0;
        step();
        step();
        chk("idle_note",    note,    0);
        chk("idle_note_on", note_on, 0);

        // Start: e0 appears one cycle after play is sampled.
        play = 1'b1;
        sb.push_back('{pos: 5'd0, note: 5'd3, len: 40, on: 38, ticks: 4});
        step();
        chk("start_note",    note,    3);
        chk("start_pos",     pos,     0);
        chk("start_note_on", note_on, 1);
        chk("start_tick",    tick,    0);
        consume(0, 0);

        // e1 with a 7-cycle pause starting at pcnt=4.
        sb.push_back('{pos: 5'd1, note: 5'd5, len: 37, on: 28, ticks: 3});
        consume(5, 7);
        sb.push_back('{pos: 5'd2, note: 5'd0, len: 10, on: 0, ticks: 1});
        consume(0, 0);
        sb.push_back('{pos: 5'd3, note: 5'd8, len: 20, on: 18, ticks: 2});
        consume(0, 0);

`ifdef SEQ_LOOP_EN
        chk("loop_pos",  pos,  0);
        chk("loop_note", note, 3);
        chk("loop_done", done, 0);
`else
        chk("end_done",    done,    1);
        chk("end_pos",     pos,     4);
        chk("end_note_on", note_on, 0);
        tk_done  = 0;
        on_done  = 0;
        done_low = 0;
        repeat (25) begin
            step();
            tk_done  += int'(tick);
            on_done  += int'(note_on);
            done_low += int'(!done);
        end
        chk("done_ticks",   tk_done,  0);
        chk("done_note_on", on_done,  0);
        chk("done_held",    done_low, 0);
`endif

        // Restart from the end of the score.
        restart = 1'b1;
        sb.push_back('{pos: 5'd0, note: 5'd3, len: 40, on: 38, ticks: 4});
        step();
        restart = 1'b0;
        chk("rs_pos",     pos,     0);
        chk("rs_note",    note,    3);
        chk("rs_done",    done,    0);
        chk("rs_note_on", note_on, 1);
        chk("rs_tick",    tick,    0);
        consume(0, 0);
        chk("rs_e1_pos", pos, 1);

        // Restart on the cycle that would produce the second tick of e1.
        repeat (19) step();
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("rt_tick",    tick,    0);
        chk("rt_pos",     pos,     0);
        chk("rt_note",    note,    3);
        chk("rt_note_on", note_on, 1);
        repeat (9) step();
        chk("rt_tick_c10", tick, 0);
        step();
        chk("rt_tick_c11", tick, 1);

        // Asynchronous reset between edges, mid-e0.
        repeat (5) step();
        #3;
        sys_RST = 1'b1;
        #1;
        chk("ar_note",    note,    0);
        chk("ar_pos",     pos,     0);
        chk("ar_note_on", note_on, 0);
        chk("ar_tick",    tick,    0);
        chk("ar_done",    done,    0);
        step();
        step();
        sys_RST = 1'b0;
        sb.push_back('{pos: 5'd0, note: 5'd3, len: 40, on: 38, ticks: 4});
        step();
        chk("ar_rel_pos",     pos,     0);
        chk("ar_rel_note",    note,    3);
        chk("ar_rel_note_on", note_on, 1);
        consume(0, 0);
        chk("ar_e1_pos",  pos,  1);
        chk("ar_e1_note", note, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
